// File: rtl/jtag_tap_master_pkg.sv
// Shared op codes and FSM state encoding for the JTAG TAP master.
package jtag_tap_master_pkg;

    localparam logic [1:0] JTAG_OP_RESET = 2'd0;
    localparam logic [1:0] JTAG_OP_IR    = 2'd1;
    localparam logic [1:0] JTAG_OP_DR    = 2'd2;
    localparam logic [1:0] JTAG_OP_IDLE  = 2'd3;

    // Each tick state names the TCK tick currently on the pins; its TMS value
    // moves the target TAP into the state the name suggests.
    typedef enum logic [3:0] {
        ST_INIT, ST_IDLE, ST_RST, ST_SELDR, ST_SELIR, ST_CAP, ST_SHIFT,
        ST_SCAN, ST_PAUSE, ST_EXIT2, ST_UPDATE, ST_RTI, ST_RESP
    } jtag_state_e;

    function automatic logic is_tick_state(input jtag_state_e s);
        return !(s == ST_IDLE || s == ST_RESP);
    endfunction

endpackage

// File: rtl/jtag_tap_master_tck_gen.sv
// TCK divider: CLK_DIV clk low then CLK_DIV clk high per tick, parked low when disabled.
module jtag_tck_gen #(
    parameter int CLK_DIV = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tck,
    output logic fall_stb,
    output logic rise_stb
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    // Strobes mark the cycle whose closing edge flips TCK.
    assign wrap     = en && (cnt == CW'(CLK_DIV - 1));
    assign rise_stb = wrap && !tck;
    assign fall_stb = wrap && tck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/jtag_tap_master.sv
// JTAG TAP master: runs reset/IR/DR/idle sequences and returns captured TDO bits.
// Define JTAG_MASTER_PAUSE_EN to route scans Exit1 -> Pause -> Exit2 -> Update.
module jtag_tap_master
    import jtag_tap_master_pkg::*;
#(
    parameter int IR_LEN      = 5,
    parameter int DR_MAX      = 40,
    parameter int CLK_DIV     = 5,
    parameter int RESET_TICKS = 8,
    localparam int LEN_W      = $clog2(DR_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DR_MAX-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DR_MAX-1:0] rsp_data,
    output logic              busy,
    output logic              jtag_TCK,
    output logic              jtag_TMS,
    output logic              jtag_TDI,
    input  logic              jtag_TDO
);
    localparam int RT_W  = $clog2(RESET_TICKS + 1);
    localparam int CNT_W = (LEN_W > RT_W) ? LEN_W : RT_W;
    localparam int IDX_W = (DR_MAX > 1) ? $clog2(DR_MAX) : 1;
    localparam logic [CNT_W-1:0] RT_LAST = CNT_W'(RESET_TICKS);

    jtag_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, n_q, n_d, len_clamped;
    logic              ir_q, ir_d, tms_q, tms_d, tdi_q, tdi_d;
    logic              busy_q, busy_d, rsp_valid_q, rsp_valid_d;
    logic [DR_MAX-1:0] sh_q, sh_d, cap_q, cap_d;
    logic              fall_stb, rise_stb;

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (is_tick_state(state_q)),
        .tck      (jtag_TCK),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb)
    );

    assign len_clamped = (cmd_len > LEN_W'(DR_MAX)) ? CNT_W'(DR_MAX) : CNT_W'(cmd_len);
    assign cmd_ready   = (state_q == ST_IDLE) && !rsp_valid_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = cap_q;
    assign busy        = busy_q;
    assign jtag_TMS    = tms_q;
    assign jtag_TDI    = tdi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            n_q         <= '0;
            ir_q        <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            sh_q        <= '0;
            cap_q       <= '0;
            busy_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            ir_q        <= ir_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            sh_q        <= sh_d;
            cap_q       <= cap_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // TMS/TDI for a tick are loaded on the edge that starts its low phase:
    // the accept edge for the first tick, the previous tick's fall edge otherwise.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        ir_d        = ir_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        sh_d        = sh_q;
        cap_d       = cap_q;
        busy_d      = busy_q;
        rsp_valid_d = rsp_valid_q;
        if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: if (cmd_valid && cmd_ready) begin
                busy_d = 1'b1;
                cnt_d  = '0;
                cap_d  = '0;
                sh_d   = cmd_data;
                ir_d   = (cmd_op == JTAG_OP_IR);
                n_d    = ir_d ? CNT_W'(IR_LEN) : len_clamped;
                case (cmd_op)
                    JTAG_OP_RESET: begin
                        state_d = ST_RST;
                        tms_d   = 1'b1;
                    end
                    JTAG_OP_IR, JTAG_OP_DR: begin
                        if (n_d == '0) state_d = ST_RESP;
                        else begin
                            state_d = ST_SELDR;
                            tms_d   = 1'b1;
                        end
                    end
                    default: begin
                        if (cmd_len == '0) state_d = ST_RESP;
                        else begin
                            state_d = ST_RTI;
                            cnt_d   = CNT_W'(cmd_len);
                            tms_d   = 1'b0;
                        end
                    end
                endcase
            end
            ST_INIT, ST_RST: if (fall_stb) begin
                if (cnt_q == RT_LAST) begin
                    state_d = (state_q == ST_INIT) ? ST_IDLE : ST_RESP;
                    busy_d  = (state_q == ST_RST);
                    cnt_d   = '0;
                    tms_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    tms_d = (cnt_q + CNT_W'(1)) != RT_LAST;
                end
            end
            ST_SELDR: if (fall_stb) begin
                state_d = ir_q ? ST_SELIR : ST_CAP;
                tms_d   = ir_q;
            end
            ST_SELIR: if (fall_stb) begin
                state_d = ST_CAP;
                tms_d   = 1'b0;
            end
            ST_CAP: if (fall_stb) begin
                state_d = ST_SHIFT;
                tms_d   = 1'b0;
            end
            ST_SHIFT: if (fall_stb) begin
                state_d = ST_SCAN;
                cnt_d   = '0;
                tms_d   = (n_q == CNT_W'(1));
                tdi_d   = sh_q[0];
                sh_d    = sh_q >> 1;
            end
            ST_SCAN: begin
                if (rise_stb) cap_d[cnt_q[IDX_W-1:0]] = jtag_TDO;
                if (fall_stb) begin
                    if (cnt_q == n_q - CNT_W'(1)) begin
                        tdi_d = 1'b0;
`ifdef JTAG_MASTER_PAUSE_EN
                        state_d = ST_PAUSE;
                        tms_d   = 1'b0;
`else
                        state_d = ST_UPDATE;
                        tms_d   = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        tms_d = (cnt_q + CNT_W'(2)) == n_q;
                        tdi_d = sh_q[0];
                        sh_d  = sh_q >> 1;
                    end
                end
            end
            ST_PAUSE: if (fall_stb) begin
                state_d = ST_EXIT2;
                tms_d   = 1'b1;
            end
            ST_EXIT2: if (fall_stb) begin
                state_d = ST_UPDATE;
                tms_d   = 1'b1;
            end
            ST_UPDATE: if (fall_stb) begin
                state_d = ST_RTI;
                cnt_d   = CNT_W'(1);
                tms_d   = 1'b0;
            end
            ST_RTI: if (fall_stb) begin
                tms_d = 1'b0;
                if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                rsp_valid_d = 1'b1;
            end
            default: state_d = ST_INIT;
        endcase
    end

endmodule

// File: tb/tb_jtag_tap_master.sv
// Randomized bench for jtag_tap_master: a behavioural TAP walker on the pins plus a spec-level TMS/latency model.
module tb_jtag_tap_master;
    localparam int IR_LEN = 5, DR_MAX = 40, CLK_DIV = 5, RESET_TICKS = 8, LEN_W = 6;
    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PDR = 6, EX2DR = 7,
                   UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PIR = 13, EX2IR = 14, UPIR = 15;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [1:0]        cmd_op;
    logic [LEN_W-1:0]  cmd_len;
    logic [DR_MAX-1:0] cmd_data, rsp_data;
    logic              jtag_TCK, jtag_TMS, jtag_TDI;
    logic              jtag_TDO = 1'b0;

    jtag_tap_master #(.IR_LEN(IR_LEN), .DR_MAX(DR_MAX), .CLK_DIV(CLK_DIV), .RESET_TICKS(RESET_TICKS)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy), .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS),
        .jtag_TDI(jtag_TDI), .jtag_TDO(jtag_TDO)
    );

    always #10 clk = ~clk;

    int   n_chk = 0, n_fail = 0;
    int   tap = TLR;
    int   b_tms = 0, b_sh = 0;
    logic tms_seq[$], tdi_sh[$], tdo_sh[$], exp_tms[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int tap_next(input int s, input logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PDR;
            PDR:   return m ? EX2DR : PDR;
            EX2DR: return m ? UPDR  : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PIR;
            PIR:   return m ? EX2IR : PIR;
            EX2IR: return m ? UPIR  : SHIR;
            UPIR:  return m ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    // Target side: TDO changes on TCK fall, everything is observed on TCK rise.
    always @(posedge jtag_TCK) begin
        tms_seq.push_back(jtag_TMS);
        if (tap == SHDR || tap == SHIR) begin
            tdi_sh.push_back(jtag_TDI);
            tdo_sh.push_back(jtag_TDO);
        end
        tap = tap_next(tap, jtag_TMS);
    end
    always @(negedge jtag_TCK) jtag_TDO = 1'($urandom_range(0, 1));

    function automatic logic [63:0] pack(input logic q[$], input int start);
        logic [63:0] v = '0;
        for (int i = start; i < q.size() && i - start < 64; i++) v[i - start] = q[i];
        return v;
    endfunction

    task automatic build_exp(input int op, input int n, input int len);
        exp_tms.delete();
        case (op)
            0: begin
                repeat (RESET_TICKS) exp_tms.push_back(1'b1);
                exp_tms.push_back(1'b0);
            end
            1, 2: if (n > 0) begin
                exp_tms.push_back(1'b1);
                if (op == 1) exp_tms.push_back(1'b1);
                exp_tms.push_back(1'b0);
                exp_tms.push_back(1'b0);
                for (int i = 0; i < n; i++) exp_tms.push_back(i == n - 1);
`ifdef JTAG_MASTER_PAUSE_EN
                exp_tms.push_back(1'b0);
                exp_tms.push_back(1'b1);
`endif
                exp_tms.push_back(1'b1);
                exp_tms.push_back(1'b0);
            end
            default: repeat (len) exp_tms.push_back(1'b0);
        endcase
    endtask

    task automatic mark();
        b_tms = tms_seq.size();
        b_sh  = tdi_sh.size();
    endtask

    task automatic init_check();
        int w = 0;
        mark();
        @(negedge clk);
        rst_n = 1'b1;
        while (!cmd_ready && w < 1000) begin @(negedge clk); w++; end
        build_exp(0, 0, 0);
        chk("init_ready", 64'(cmd_ready), 64'd1);
        chk("init_ticks", 64'(tms_seq.size() - b_tms), 64'(exp_tms.size()));
        chk("init_tms", pack(tms_seq, b_tms), pack(exp_tms, 0));
        chk("init_tap", 64'(tap), 64'(RTI));
        chk("init_busy", 64'(busy), 64'd0);
        chk("init_pins", 64'({jtag_TCK, jtag_TMS, jtag_TDI}), 64'd0);
    endtask

    task automatic send_cmd(input int op, input int len, input logic [DR_MAX-1:0] data);
        int w = 0;
        while (!cmd_ready && w < 1000) begin @(negedge clk); w++; end
        chk("cmd_ready", 64'(cmd_ready), 64'd1);
        mark();
        cmd_op = 2'(op); cmd_len = LEN_W'(len); cmd_data = data; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("busy_rise", 64'(busy), 64'd1);
        chk("ready_drop", 64'(cmd_ready), 64'd0);
    endtask

    task automatic do_cmd(input int op, input int len, input logic [DR_MAX-1:0] data);
        int n, lat, hold;
        logic [63:0] mask;
        logic [DR_MAX-1:0] snap;
        n = (op == 1) ? IR_LEN : (op == 2) ? ((len > DR_MAX) ? DR_MAX : len) : 0;
        build_exp(op, n, len);
        send_cmd(op, len, data);
        lat = 1;
        while (!rsp_valid && lat < 5000) begin @(negedge clk); lat++; end
        chk($sformatf("latency op%0d len%0d", op, len), 64'(lat), 64'(2 * CLK_DIV * exp_tms.size() + 2));
        chk("busy_fall", 64'(busy), 64'd0);
        chk("ticks", 64'(tms_seq.size() - b_tms), 64'(exp_tms.size()));
        chk("tms_seq", pack(tms_seq, b_tms), pack(exp_tms, 0));
        chk("tap_end", 64'(tap), 64'(RTI));
        chk("nshift", 64'(tdi_sh.size() - b_sh), 64'(n));
        mask = (64'd1 << n) - 64'd1;
        chk("tdi_bits", pack(tdi_sh, b_sh), {24'd0, data} & mask);
        chk("rsp_data", {24'd0, rsp_data}, pack(tdo_sh, b_sh));
        snap = rsp_data;
        hold = $urandom_range(0, 3);
        repeat (hold) @(negedge clk);
        chk("rsp_hold", 64'(rsp_valid), 64'd1);
        chk("rsp_stable", {24'd0, rsp_data}, {24'd0, snap});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_clear", 64'(rsp_valid), 64'd0);
        chk("ready_back", 64'(cmd_ready), 64'd1);
        chk("idle_pins", 64'({jtag_TCK, jtag_TMS, jtag_TDI}), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] r;
        int w, op, len;
        cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_data = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pins", 64'({jtag_TCK, jtag_TMS, jtag_TDI}), 64'b010);
        chk("rst_hs", 64'({cmd_ready, rsp_valid, busy}), 64'b001);
        chk("rst_data", 64'(rsp_data), 64'd0);
        init_check();

        do_cmd(1, 0, 40'h11);
        do_cmd(2, 40, {6'h10, 32'h0, 2'b10});
        do_cmd(2, 40, {6'h11, 32'h0, 2'b01});
        do_cmd(3, 0, 40'hFF);
        do_cmd(2, 0, 40'h3);
        r = {$urandom, $urandom};
        do_cmd(2, 63, r[DR_MAX-1:0]);
        do_cmd(0, 0, 40'h0);
        do_cmd(3, 7, 40'h1);
        do_cmd(2, 1, 40'h1);

        // Reset in the middle of a DR shift.
        r = {$urandom, $urandom};
        send_cmd(2, 40, r[DR_MAX-1:0]);
        w = 0;
        while (tdi_sh.size() - b_sh < 20 && w < 5000) begin @(negedge clk); w++; end
        chk("mid_shift_reached", 64'(tdi_sh.size() - b_sh), 64'd20);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_pins", 64'({jtag_TCK, jtag_TMS, jtag_TDI}), 64'b010);
        chk("mid_rst_hs", 64'({cmd_ready, rsp_valid, busy}), 64'b001);
        chk("mid_rst_data", 64'(rsp_data), 64'd0);
        repeat (2) @(negedge clk);
        init_check();
        do_cmd(2, 40, {6'h10, 32'h0, 2'b10});

        for (int i = 0; i < 14; i++) begin
            op  = $urandom_range(0, 3);
            len = (op == 3) ? $urandom_range(0, 12) : $urandom_range(0, 63);
            r   = {$urandom, $urandom};
            do_cmd(op, len, r[DR_MAX-1:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
